// File: rtl/playfield_vram_ctrl.sv
// playfield_vram_ctrl: SDRAM command sequencer for a block-puzzle playfield.
// Background fill, piece erase/draw, row burst reads and line-clear copies.

module playfield_vram_ctrl #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int N_CELLS = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 25,
    parameter logic [DATA_W-1:0] BG_COLOR = 16'h000F
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      vs,
    input  logic [N_CELLS*7-1:0]      pre_x,
    input  logic [N_CELLS*7-1:0]      pre_y,
    input  logic [N_CELLS-1:0]        pre_valid,
    input  logic [N_CELLS*7-1:0]      post_x,
    input  logic [N_CELLS*7-1:0]      post_y,
    input  logic [N_CELLS-1:0]        post_valid,
    input  logic [DATA_W-1:0]         piece_color,
    input  logic                      row_ld,
    input  logic [7:0]                row,
    input  logic                      clear_req,
    input  logic [7:0]                clear_row,
    input  logic [15:0]               wr_buffer,
    input  logic [15:0]               rd_buffer,
    input  logic [DATA_W-1:0]         readdata,
    output logic                      write_ld,
    output logic                      write_req,
    output logic [ADDR_W-1:0]         writeaddr,
    output logic [DATA_W-1:0]         writedata,
    output logic                      read_ld,
    output logic                      read_req,
    output logic [ADDR_W-1:0]         readaddr,
    output logic [BOARD_W*DATA_W-1:0] row_data,
    output logic                      row_ready,
    output logic                      clear_done,
    output logic                      busy
);

    localparam int CNT_W = 16;
    localparam int IDX_W = (BOARD_W > 1) ? $clog2(BOARD_W) : 1;

    typedef enum logic [2:0] {
        ST_INIT, ST_IDLE, ST_ERASE, ST_DRAW, ST_RD_ROW, ST_CLR_COPY, ST_CLR_TOP
    } state_t;

    typedef enum logic [2:0] {
        S_NONE, S_WLD, S_WREQ, S_WWAIT, S_RLD, S_RWAIT, S_RREQ, S_RTAIL
    } sub_t;

    state_t             state_q, state_d;
    sub_t               sub_q, sub_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         r_q, r_d;
    logic [7:0]         row_q, row_d;
    logic               ph_q, ph_d;
    logic               flag_q, flag_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [IDX_W-1:0]   rk_q, rk_d;
    logic               cap_v_q;
    logic [IDX_W-1:0]   cap_k_q;
    logic               busy_q;
    logic [DATA_W-1:0]  buf_q [BOARD_W];

    logic [6:0]         cx, cy;
    logic               cv, cell_ok;
    logic [ADDR_W-1:0]  cell_addr;

    function automatic logic [ADDR_W-1:0] row_base(input logic [7:0] r);
        return ADDR_W'(BOARD_W) * ADDR_W'(r);
    endfunction

    // Select the current piece cell (old cells in ERASE, new cells otherwise).
    always_comb begin
        cx = '0;
        cy = '0;
        cv = 1'b0;
        for (int k = 0; k < N_CELLS; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                if (state_q == ST_ERASE) begin
                    cx = pre_x[k*7 +: 7];
                    cy = pre_y[k*7 +: 7];
                    cv = pre_valid[k];
                end else begin
                    cx = post_x[k*7 +: 7];
                    cy = post_y[k*7 +: 7];
                    cv = post_valid[k];
                end
            end
        end
    end

    assign cell_ok   = cv && (cx < 7'(BOARD_W)) && (cy < 7'(BOARD_H));
    assign cell_addr = ADDR_W'(BOARD_W) * ADDR_W'(cy) + ADDR_W'(cx);

    // Next state: a running SDRAM sub-sequence owns the cycle, else the main FSM.
    always_comb begin
        state_d    = state_q;
        sub_d      = sub_q;
        cnt_d      = cnt_q;
        r_d        = r_q;
        row_d      = row_q;
        ph_d       = ph_q;
        flag_d     = flag_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rk_d       = rk_q;
        row_ready  = 1'b0;
        clear_done = 1'b0;
        unique case (sub_q)
            S_WLD:   sub_d = S_WREQ;
            S_WREQ:  sub_d = S_WWAIT;
            S_WWAIT: begin
                if (wr_buffer == '0) begin
                    sub_d = S_NONE;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RLD:   sub_d = S_RWAIT;
            S_RWAIT: begin
                if (rd_buffer == 16'(BOARD_W)) begin
                    sub_d = S_RREQ;
                    rk_d  = '0;
                end
            end
            S_RREQ: begin
                rk_d = rk_q + 1'b1;
                if (rk_q == IDX_W'(BOARD_W - 1)) sub_d = S_RTAIL;
            end
            S_RTAIL: begin
                sub_d = S_NONE;
                ph_d  = 1'b1;
                cnt_d = '0;
            end
            default: begin
                unique case (state_q)
                    ST_INIT: begin
                        if (cnt_q < CNT_W'(BOARD_W * BOARD_H)) begin
                            addr_d  = ADDR_W'(cnt_q);
                            wdata_d = BG_COLOR;
                            sub_d   = S_WLD;
                        end else begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end
                    end
                    ST_IDLE: begin
                        if (!vs) flag_d = 1'b0;
                        if (vs && !flag_q) begin
                            flag_d  = 1'b1;
                            state_d = ST_ERASE;
                            cnt_d   = '0;
                        end else if (clear_req) begin
                            state_d = ST_CLR_COPY;
                            r_d     = clear_row;
                            ph_d    = 1'b0;
                            cnt_d   = '0;
                        end else if (row_ld) begin
                            state_d = ST_RD_ROW;
                            row_d   = row;
                            ph_d    = 1'b0;
                        end
                    end
                    ST_ERASE, ST_DRAW: begin
                        if (cnt_q < CNT_W'(N_CELLS)) begin
                            if (cell_ok) begin
                                addr_d  = cell_addr;
                                wdata_d = (state_q == ST_ERASE) ? BG_COLOR
                                                                : piece_color;
                                sub_d   = S_WLD;
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end else begin
                            cnt_d   = '0;
                            state_d = (state_q == ST_ERASE) ? ST_DRAW : ST_IDLE;
                        end
                    end
                    ST_RD_ROW: begin
                        if (row_q >= 8'(BOARD_H) || ph_q) begin
                            row_ready = 1'b1;
                            ph_d      = 1'b0;
                            state_d   = ST_IDLE;
                        end else begin
                            addr_d = row_base(row_q);
                            sub_d  = S_RLD;
                        end
                    end
                    ST_CLR_COPY: begin
                        if (r_q >= 8'(BOARD_H)) begin
                            clear_done = 1'b1;
                            state_d    = ST_IDLE;
                        end else if (r_q == '0) begin
                            state_d = ST_CLR_TOP;
                            cnt_d   = '0;
                        end else if (!ph_q) begin
                            addr_d = row_base(r_q - 8'd1);
                            sub_d  = S_RLD;
                        end else if (cnt_q < CNT_W'(BOARD_W)) begin
                            addr_d  = row_base(r_q) + ADDR_W'(cnt_q);
                            wdata_d = buf_q[cnt_q[IDX_W-1:0]];
                            sub_d   = S_WLD;
                        end else begin
                            r_d   = r_q - 8'd1;
                            ph_d  = 1'b0;
                            cnt_d = '0;
                        end
                    end
                    ST_CLR_TOP: begin
                        if (cnt_q < CNT_W'(BOARD_W)) begin
                            addr_d  = ADDR_W'(cnt_q);
                            wdata_d = BG_COLOR;
                            sub_d   = S_WLD;
                        end else begin
                            clear_done = 1'b1;
                            state_d    = ST_IDLE;
                        end
                    end
                    default: state_d = ST_INIT;
                endcase
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_INIT;
            sub_q   <= S_NONE;
            cnt_q   <= '0;
            r_q     <= '0;
            row_q   <= '0;
            ph_q    <= 1'b0;
            flag_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rk_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sub_q   <= sub_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            row_q   <= row_d;
            ph_q    <= ph_d;
            flag_q  <= flag_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rk_q    <= rk_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    // Capture each burst word one cycle after its read strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_v_q <= 1'b0;
            cap_k_q <= '0;
            for (int k = 0; k < BOARD_W; k++) buf_q[k] <= '0;
        end else begin
            cap_v_q <= (sub_q == S_RREQ);
            cap_k_q <= rk_q;
            if (cap_v_q) buf_q[cap_k_q] <= readdata;
        end
    end

    genvar g;
    generate
        for (g = 0; g < BOARD_W; g++) begin : g_pack
            assign row_data[g*DATA_W +: DATA_W] = buf_q[g];
        end
    endgenerate

    assign write_ld  = (sub_q == S_WLD);
    assign write_req = (sub_q == S_WREQ);
    assign read_ld   = (sub_q == S_RLD);
    assign read_req  = (sub_q == S_RREQ);
    assign writeaddr = addr_q;
    assign readaddr  = addr_q;
    assign writedata = wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_playfield_vram_ctrl.sv
// tb_playfield_vram_ctrl: scoreboard bench with an SDRAM responder model.
// Directed vectors push expected commands; a negedge monitor pops and checks.

module tb_playfield_vram_ctrl;

    localparam int K_W    = 0;
    localparam int K_R    = 1;
    localparam int K_RDY  = 2;
    localparam int K_DONE = 3;

    typedef struct {
        int          kind;
        int          addr;
        logic [15:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          vs = 1'b0;
    logic [27:0]   pre_x = '0, pre_y = '0, post_x = '0, post_y = '0;
    logic [3:0]    pre_valid = '0, post_valid = '0;
    logic [15:0]   piece_color = '0;
    logic          row_ld = 1'b0;
    logic [7:0]    row = '0;
    logic          clear_req = 1'b0;
    logic [7:0]    clear_row = '0;
    logic [15:0]   wr_buffer = '0, rd_buffer = '0;
    logic [15:0]   readdata = '0;
    logic          write_ld, write_req, read_ld, read_req;
    logic [24:0]   writeaddr, readaddr;
    logic [15:0]   writedata;
    logic [159:0]  row_data;
    logic          row_ready, clear_done, busy;

    int            n_chk = 0;
    int            n_fail = 0;
    exp_t          exp_q[$];
    logic [15:0]   mem [0:199];
    logic [24:0]   wa;
    int            rbase, ridx, rd_delay, wb_cnt, runlen;
    bit            prev_req, wb_slow;

    playfield_vram_ctrl dut (
        .clk(clk), .reset(reset), .vs(vs),
        .pre_x(pre_x), .pre_y(pre_y), .pre_valid(pre_valid),
        .post_x(post_x), .post_y(post_y), .post_valid(post_valid),
        .piece_color(piece_color), .row_ld(row_ld), .row(row),
        .clear_req(clear_req), .clear_row(clear_row),
        .wr_buffer(wr_buffer), .rd_buffer(rd_buffer), .readdata(readdata),
        .write_ld(write_ld), .write_req(write_req),
        .writeaddr(writeaddr), .writedata(writedata),
        .read_ld(read_ld), .read_req(read_req), .readaddr(readaddr),
        .row_data(row_data), .row_ready(row_ready),
        .clear_done(clear_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [191:0] act,
                       input logic [191:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int kind, input int addr, input logic [15:0] d);
        exp_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic expect_pop(input int kind, input int addr,
                              input logic [15:0] d);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected event kind %0d addr %0d data %0h",
                     kind, addr, d);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", 192'(kind), 192'(e.kind));
            chk("event_addr", 192'(addr), 192'(e.addr));
            chk("event_data", 192'(d), 192'(e.data));
        end
    endtask

    function automatic logic [159:0] rowpat(input logic [15:0] base);
        logic [159:0] r;
        for (int k = 0; k < 10; k++) r[k*16 +: 16] = base + 16'(k);
        return r;
    endfunction

    task automatic set_pre(input int i, input int x, input int y);
        pre_x[i*7 +: 7] = 7'(x);
        pre_y[i*7 +: 7] = 7'(y);
    endtask

    task automatic set_post(input int i, input int x, input int y);
        post_x[i*7 +: 7] = 7'(x);
        post_y[i*7 +: 7] = 7'(y);
    endtask

    task automatic push_init();
        for (int a = 0; a < 200; a++) push(K_W, a, 16'h000F);
    endtask

    task automatic drain(input string nm, input int budget);
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_pending"}, 192'(exp_q.size()), 192'(0));
        chk({nm, "_busy"}, 192'(busy), 192'(0));
        exp_q.delete();
    endtask

    task automatic serve_reqs(input int budget);
        int t = 0;
        while ((row_ld || clear_req) && t < budget) begin
            @(negedge clk);
            if (row_ready) row_ld = 1'b0;
            if (clear_done) clear_req = 1'b0;
            t++;
        end
        chk("req_handshake", 192'({row_ld, clear_req}), 192'(0));
        row_ld = 1'b0;
        clear_req = 1'b0;
    endtask

    // Monitor plus SDRAM responder: checks first, then updates the model.
    always @(negedge clk) begin
        if (!reset) begin
            prev_req  = 1'b0;
            rd_delay  = 0;
            wb_cnt    = 0;
            runlen    = 0;
            rd_buffer = '0;
            wr_buffer = '0;
            readdata  = '0;
        end else begin
            if (write_req || read_req)
                chk("req_exclusive", 192'(write_req & read_req), 192'(0));
            if (write_ld || read_ld) begin
                chk("ld_exclusive", 192'(write_ld & read_ld), 192'(0));
                chk("ld_wr_buffer_hold", 192'(wr_buffer), 192'(0));
            end
            if (write_ld) wa = writeaddr;
            if (write_req) begin
                expect_pop(K_W, int'(wa), writedata);
                if (wa < 200) mem[wa] = writedata;
                if (wb_slow) begin
                    wr_buffer = 16'd2;
                    wb_cnt = 4;
                end
            end
            if (read_ld) begin
                expect_pop(K_R, int'(readaddr), 16'h0);
                rbase = int'(readaddr);
                ridx = 0;
                rd_delay = 3;
            end
            if (read_req) begin
                runlen++;
            end else if (runlen > 0) begin
                chk("burst_len", 192'(runlen), 192'(10));
                runlen = 0;
            end
            if (row_ready) expect_pop(K_RDY, 0, 16'h0);
            if (clear_done) expect_pop(K_DONE, 0, 16'h0);
            if (wb_cnt > 0) begin
                wb_cnt--;
                if (wb_cnt == 0) wr_buffer = '0;
            end
            if (rd_delay > 0) begin
                rd_delay--;
                if (rd_delay == 0) rd_buffer = 16'd10;
            end
            if (read_req) rd_buffer = '0;
            if (prev_req) begin
                readdata = (rbase + ridx < 200) ? mem[rbase + ridx] : 16'hDEAD;
                ridx++;
            end
            prev_req = read_req;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int a = 0; a < 200; a++) mem[a] = '0;
        wb_slow = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_strobes", 192'({write_ld, write_req, read_ld, read_req,
                                 row_ready, clear_done, busy}), 192'(0));
        chk("rst_addr", 192'({writeaddr, readaddr}), 192'(0));
        chk("rst_wdata", 192'(writedata), 192'(0));
        chk("rst_row_data", 192'(row_data), 192'(0));

        push_init();
        reset = 1'b1;
        drain("init", 2000);

        for (int i = 0; i < 4; i++) begin
            set_pre(i, i, 0);
            set_post(i, i, 1);
        end
        pre_valid = 4'b1111;
        post_valid = 4'b1111;
        piece_color = 16'h0F00;
        for (int i = 0; i < 4; i++) push(K_W, i, 16'h000F);
        for (int i = 0; i < 4; i++) push(K_W, 10 + i, 16'h0F00);
        wb_slow = 1'b1;
        vs = 1'b1;
        drain("update", 400);
        repeat (20) @(negedge clk);
        chk("vs_held_no_update", 192'(busy), 192'(0));
        vs = 1'b0;
        wb_slow = 1'b0;
        repeat (2) @(negedge clk);

        pre_valid = 4'b0000;
        post_valid = 4'b0101;
        set_post(2, 12, 1);
        push(K_W, 10, 16'h0F00);
        vs = 1'b1;
        drain("skip_cells", 200);
        vs = 1'b0;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 10; k++) mem[50 + k] = 16'hA0 + 16'(k);
        push(K_R, 50, 16'h0);
        push(K_RDY, 0, 16'h0);
        row = 8'd5;
        row_ld = 1'b1;
        serve_reqs(200);
        drain("row_read", 50);
        chk("row_data_r5", 192'(row_data), 192'(rowpat(16'hA0)));

        push(K_RDY, 0, 16'h0);
        row = 8'd25;
        row_ld = 1'b1;
        serve_reqs(50);
        drain("row_oob", 50);
        chk("row_data_kept", 192'(row_data), 192'(rowpat(16'hA0)));

        for (int k = 0; k < 10; k++) begin
            mem[k] = 16'hC0 + 16'(k);
            mem[10 + k] = 16'hB0 + 16'(k);
        end
        push(K_R, 10, 16'h0);
        for (int k = 0; k < 10; k++) push(K_W, 20 + k, 16'hB0 + 16'(k));
        push(K_R, 0, 16'h0);
        for (int k = 0; k < 10; k++) push(K_W, 10 + k, 16'hC0 + 16'(k));
        for (int k = 0; k < 10; k++) push(K_W, k, 16'h000F);
        push(K_DONE, 0, 16'h0);
        clear_row = 8'd2;
        clear_req = 1'b1;
        serve_reqs(600);
        drain("clear2", 50);

        push(K_DONE, 0, 16'h0);
        clear_row = 8'd30;
        clear_req = 1'b1;
        serve_reqs(50);
        drain("clear_oob", 50);

        for (int i = 0; i < 4; i++) begin
            set_pre(i, 5 + i, 10);
            set_post(i, 5 + i, 11);
        end
        pre_valid = 4'b1111;
        post_valid = 4'b1111;
        piece_color = 16'h00F0;
        for (int i = 0; i < 4; i++) push(K_W, 105 + i, 16'h000F);
        for (int i = 0; i < 4; i++) push(K_W, 115 + i, 16'h00F0);
        push(K_R, 0, 16'h0);
        for (int k = 0; k < 10; k++) push(K_W, 10 + k, 16'h000F);
        for (int k = 0; k < 10; k++) push(K_W, k, 16'h000F);
        push(K_DONE, 0, 16'h0);
        push(K_R, 50, 16'h0);
        push(K_RDY, 0, 16'h0);
        vs = 1'b1;
        clear_row = 8'd1;
        clear_req = 1'b1;
        row = 8'd5;
        row_ld = 1'b1;
        serve_reqs(800);
        drain("priority", 100);
        chk("row_data_prio", 192'(row_data), 192'(rowpat(16'hA0)));
        vs = 1'b0;
        repeat (2) @(negedge clk);

        push(K_R, 20, 16'h0);
        for (int k = 0; k < 10; k++) push(K_W, 30 + k, 16'hB0 + 16'(k));
        clear_row = 8'd3;
        clear_req = 1'b1;
        repeat (25) @(negedge clk);
        chk("busy_before_reset", 192'(busy), 192'(1));
        @(posedge clk);
        #3;
        reset = 1'b0;
        exp_q.delete();
        clear_req = 1'b0;
        #1;
        chk("midrst_strobes", 192'({write_ld, write_req, read_ld, read_req,
                                    row_ready, clear_done, busy}), 192'(0));
        chk("midrst_addr", 192'({writeaddr, readaddr, writedata}), 192'(0));
        chk("midrst_row_data", 192'(row_data), 192'(0));
        repeat (3) @(negedge clk);
        push_init();
        reset = 1'b1;
        drain("reinit", 2000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
